micro_seq: RTL and testbench
============================

// Module: micro_seq
// PURPOSE
//  Microprogram sequencer: upstream of the 256x24 control ROM and the 24-bit microinstruction register.
//  Generates the 8-bit micro-address (addr_pc) and the UIR load strobe. It decodes the sequencing
//  field of the current microinstruction to pick NEXT/JUMP/BRANCH/MAP/CALL/RET/HALT.
//  Replaces the free-running 74LS161 address counter. addr_pc also drives the LED address display.
// PARAMETERS
//  START_ADDR   8'h00  micro-address loaded on reset
//  STACK_DEPTH  4      micro-call return stack entries (1..8)
//  MAP_SHIFT    4      MAP target = {ir_op, MAP_SHIFT zeros} truncated to 8 bits
// PORTS
//  clk       in   1   system clock; all logic on posedge
//  rst       in   1   synchronous, active-high reset
//  uir       in   24  current microinstruction (UIR output); [23:16]=NA, [15:13]=SEQ
//  ir_op     in   4   opcode field of the machine instruction register, used by MAP
//  flag_z    in   1   ALU zero flag
//  flag_c    in   1   ALU carry flag
//  addr_pc   out  8   micro-address to ROM address input
//  uir_ld    out  1   one-cycle strobe; UIR captures ROM q on this cycle's posedge
//  halted    out  1   high in S_HALT
//  err       out  1   sticky: stack overflow or underflow
// BEHAVIOUR
//  Reset (rst=1 at posedge): addr_pc=START_ADDR, state=S_FETCH, stack pointer=0, uir_ld=0, halted=0, err=0.
//  FSM, one microinstruction per 3 clocks:
//   S_FETCH -> S_LATCH: addr_pc is stable; ROM registers q (1-cycle ROM latency).
//   S_LATCH -> S_EXEC: uir_ld=1 for exactly this cycle.
//   S_EXEC  -> S_FETCH or S_HALT: uir is valid. Compute next addr_pc from SEQ:
//    000 NEXT: addr_pc+1, wraps 8'hFF->8'h00
//    001 JUMP: NA
//    010 BRZ:  flag_z ? NA : addr_pc+1
//    011 BRC:  flag_c ? NA : addr_pc+1
//    100 MAP:  ({4'b0,ir_op} << MAP_SHIFT) [7:0]
//    101 CALL: push addr_pc+1 (wrapped), jump NA. If stack is full: no push, err<=1, go S_HALT.
//    110 RET:  pop into addr_pc. If stack is empty: err<=1, go S_HALT, addr_pc unchanged.
//    111 HALT: addr_pc unchanged, go S_HALT.
//  Flags are sampled only in the S_EXEC cycle.
//  S_HALT: absorbing. addr_pc holds, uir_ld=0, halted=1. Only rst exits.
//  Stack: LIFO, depth STACK_DEPTH. Pointer width is clog2(STACK_DEPTH+1). Entries are not cleared on reset.
//  rst has priority in every state. Asserting it mid-instruction (incl. the uir_ld cycle) aborts the
//  instruction; no push or pop takes effect.
//  addr_pc, uir_ld, halted and err are all registered; no combinational input->output paths.
// CONFIGURATION
//  MICRO_SEQ_SINGLE_STEP_EN defined: adds input port step (1 bit, debounced, one-clk pulse).
//   S_EXEC holds (no address update, no push/pop) until step=1. step outside S_EXEC is ignored.
//   Each step advances exactly one microinstruction.
//  Not defined: no step port; S_EXEC always advances after one cycle (free-running).
// TESTING
//  1 Reset, all uir SEQ=000 -> addr_pc 00,01,02,... every 3 clks; uir_ld pulses once per instruction.
//  2 addr_pc=FF with NEXT -> addr_pc=00; err=0.
//  3 SEQ=010 NA=40: flag_z=1 -> addr_pc=40; flag_z=0 -> addr_pc=addr+1. Repeat for BRC with flag_c.
//  4 ir_op=4'hA, SEQ=100, MAP_SHIFT=4 -> addr_pc=A0. CALL NA=80 at addr 10, then RET -> addr_pc=11.
//  5 STACK_DEPTH+1 nested CALLs -> last one sets err=1 and halted=1; RET on empty stack after reset -> err=1.
//  6 Assert rst during the uir_ld cycle of a CALL -> addr_pc=START_ADDR, stack empty, err=0.
//    With MICRO_SEQ_SINGLE_STEP_EN: addr_pc holds until step=1.

Source files
------------

// File: rtl/micro_seq.sv
// Microprogram sequencer: fetch/latch/exec FSM producing the control-ROM address and UIR load strobe.
// Optional MICRO_SEQ_SINGLE_STEP_EN adds a step input that gates each microinstruction in S_EXEC.
module micro_seq #(
  parameter logic [7:0] START_ADDR  = 8'h00,
  parameter int         STACK_DEPTH = 4,
  parameter int         MAP_SHIFT   = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MICRO_SEQ_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [23:0] uir,
  input  logic [3:0]  ir_op,
  input  logic        flag_z,
  input  logic        flag_c,
  output logic [7:0]  addr_pc,
  output logic        uir_ld,
  output logic        halted,
  output logic        err
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  typedef enum logic [1:0] {S_FETCH, S_LATCH, S_EXEC, S_HALT} state_t;

  localparam logic [2:0] SEQ_NEXT = 3'b000;
  localparam logic [2:0] SEQ_JUMP = 3'b001;
  localparam logic [2:0] SEQ_BRZ  = 3'b010;
  localparam logic [2:0] SEQ_BRC  = 3'b011;
  localparam logic [2:0] SEQ_MAP  = 3'b100;
  localparam logic [2:0] SEQ_CALL = 3'b101;
  localparam logic [2:0] SEQ_RET  = 3'b110;

  state_t          state;
  logic [SP_W-1:0] sp;
  logic [7:0]      stack [STACK_DEPTH];

  logic [7:0]      na;
  logic [2:0]      seq;
  logic [7:0]      pc_inc;
  logic [7:0]      map_addr;
  logic [7:0]      top_entry;
  logic            full;
  logic            empty;
  logic            advance;
  logic            push_en;
  logic            unused_uir_bits;

  assign na              = uir[23:16];
  assign seq             = uir[15:13];
  assign unused_uir_bits = ^uir[12:0];
  assign pc_inc          = addr_pc + 8'd1;
  assign map_addr        = {4'b0000, ir_op} << MAP_SHIFT;
  assign full            = (sp == SP_W'(STACK_DEPTH));
  assign empty           = (sp == '0);

`ifdef MICRO_SEQ_SINGLE_STEP_EN
  assign advance = (state == S_EXEC) && step;
`else
  assign advance = (state == S_EXEC);
`endif

  assign push_en = advance && (seq == SEQ_CALL) && !full;

  always_comb begin
    top_entry = 8'h00;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp == SP_W'(i + 1)) top_entry = stack[i];
    end
  end

  // Return-address storage is data only; its contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && push_en) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (sp == SP_W'(i)) stack[i] <= pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      addr_pc <= START_ADDR;
      sp      <= '0;
      uir_ld  <= 1'b0;
      halted  <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          state  <= S_LATCH;
          uir_ld <= 1'b1;
        end
        S_LATCH: begin
          state  <= S_EXEC;
          uir_ld <= 1'b0;
        end
        S_EXEC: begin
          uir_ld <= 1'b0;
          if (advance) begin
            state <= S_FETCH;
            case (seq)
              SEQ_NEXT: addr_pc <= pc_inc;
              SEQ_JUMP: addr_pc <= na;
              SEQ_BRZ:  addr_pc <= flag_z ? na : pc_inc;
              SEQ_BRC:  addr_pc <= flag_c ? na : pc_inc;
              SEQ_MAP:  addr_pc <= map_addr;
              SEQ_CALL: begin
                if (full) begin
                  err    <= 1'b1;
                  halted <= 1'b1;
                  state  <= S_HALT;
                end else begin
                  sp      <= sp + SP_W'(1);
                  addr_pc <= na;
                end
              end
              SEQ_RET: begin
                if (empty) begin
                  err    <= 1'b1;
                  halted <= 1'b1;
                  state  <= S_HALT;
                end else begin
                  sp      <= sp - SP_W'(1);
                  addr_pc <= top_entry;
                end
              end
              default: begin
                halted <= 1'b1;
                state  <= S_HALT;
              end
            endcase
          end
        end
        default: begin
          uir_ld <= 1'b0;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_micro_seq.sv
// Directed bench for micro_seq: reset, sequencing codes, stack limits and mid-instruction reset.
// Build with MICRO_SEQ_SINGLE_STEP_EN to exercise the step-gated variant.
module tb_micro_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] uir = 24'h0;
  logic [3:0]  ir_op = 4'h0;
  logic        flag_z = 1'b0;
  logic        flag_c = 1'b0;
  logic [7:0]  addr_pc;
  logic        uir_ld;
  logic        halted;
  logic        err;
`ifdef MICRO_SEQ_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  micro_seq #(.START_ADDR(8'h00), .STACK_DEPTH(4), .MAP_SHIFT(4)) dut (
    .clk(clk),
    .rst(rst),
`ifdef MICRO_SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .uir(uir),
    .ir_op(ir_op),
    .flag_z(flag_z),
    .flag_c(flag_c),
    .addr_pc(addr_pc),
    .uir_ld(uir_ld),
    .halted(halted),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mk(input logic [2:0] seq, input logic [7:0] na);
    return {na, seq, 13'h0000};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Waits for the uir_ld cycle, then lets the instruction execute; returns #1 after the update edge.
  task automatic do_instr(input logic [23:0] u);
    bit seen;
    logic [7:0] hold;
    uir = u;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (uir_ld === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL uir_ld_timeout: no strobe within 8 cycles (addr_pc=%h)", addr_pc);
      return;
    end
    @(posedge clk);
`ifdef MICRO_SEQ_SINGLE_STEP_EN
    #1 hold = addr_pc;
    repeat (2) @(posedge clk);
    #1 n_vec++;
    if (addr_pc !== hold) begin
      n_err++;
      $display("FAIL step_hold: addr_pc=%h required %h", addr_pc, hold);
    end
    step = 1'b1;
`else
    hold = 8'h00;
`endif
    @(posedge clk);
    #1;
`ifdef MICRO_SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (addr_pc !== 8'h00) begin n_err++; $display("FAIL reset_addr: got %h want 00", addr_pc); end
    n_vec++;
    if (uir_ld !== 1'b0) begin n_err++; $display("FAIL reset_uir_ld: got %b want 0", uir_ld); end
    n_vec++;
    if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_vec++;
    if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_next();
    int pulses;
    for (int k = 1; k <= 3; k++) begin
      do_instr(mk(3'b000, 8'h77));
      n_vec++;
      if (addr_pc !== 8'(k)) begin n_err++; $display("FAIL next_%0d: got %h want %h", k, addr_pc, 8'(k)); end
    end
`ifndef MICRO_SEQ_SINGLE_STEP_EN
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (uir_ld === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 1) begin n_err++; $display("FAIL ld_per_instr: got %0d pulses want 1", pulses); end
    @(posedge clk);
    #1;
`endif
  endtask

  task automatic test_wrap();
    do_instr(mk(3'b001, 8'hFF));
    n_vec++;
    if (addr_pc !== 8'hFF) begin n_err++; $display("FAIL jump_ff: got %h want ff", addr_pc); end
    do_instr(mk(3'b000, 8'h00));
    n_vec++;
    if (addr_pc !== 8'h00) begin n_err++; $display("FAIL wrap: got %h want 00", addr_pc); end
    n_vec++;
    if (err !== 1'b0) begin n_err++; $display("FAIL wrap_err: got %b want 0", err); end
  endtask

  task automatic test_branch();
    do_instr(mk(3'b001, 8'h20));
    flag_z = 1'b1; flag_c = 1'b0;
    do_instr(mk(3'b010, 8'h40));
    n_vec++;
    if (addr_pc !== 8'h40) begin n_err++; $display("FAIL brz_taken: got %h want 40", addr_pc); end
    flag_z = 1'b0; flag_c = 1'b1;
    do_instr(mk(3'b010, 8'h60));
    n_vec++;
    if (addr_pc !== 8'h41) begin n_err++; $display("FAIL brz_not_taken: got %h want 41", addr_pc); end
    do_instr(mk(3'b011, 8'h50));
    n_vec++;
    if (addr_pc !== 8'h50) begin n_err++; $display("FAIL brc_taken: got %h want 50", addr_pc); end
    flag_z = 1'b1; flag_c = 1'b0;
    do_instr(mk(3'b011, 8'h70));
    n_vec++;
    if (addr_pc !== 8'h51) begin n_err++; $display("FAIL brc_not_taken: got %h want 51", addr_pc); end
    flag_z = 1'b0;
  endtask

  task automatic test_map_call_ret();
    ir_op = 4'hA;
    do_instr(mk(3'b100, 8'h33));
    n_vec++;
    if (addr_pc !== 8'hA0) begin n_err++; $display("FAIL map: got %h want a0", addr_pc); end
    do_instr(mk(3'b001, 8'h10));
    do_instr(mk(3'b101, 8'h80));
    n_vec++;
    if (addr_pc !== 8'h80) begin n_err++; $display("FAIL call: got %h want 80", addr_pc); end
    do_instr(mk(3'b000, 8'h00));
    do_instr(mk(3'b110, 8'h99));
    n_vec++;
    if (addr_pc !== 8'h11) begin n_err++; $display("FAIL ret: got %h want 11", addr_pc); end
    n_vec++;
    if (err !== 1'b0 || halted !== 1'b0) begin
      n_err++; $display("FAIL call_ret_flags: err=%b halted=%b want 0 0", err, halted);
    end
  endtask

  task automatic test_stack_limits();
    do_reset();
    for (int k = 1; k <= 4; k++) do_instr(mk(3'b101, 8'(k * 16)));
    n_vec++;
    if (addr_pc !== 8'h40 || err !== 1'b0) begin
      n_err++; $display("FAIL call_depth4: addr=%h err=%b want 40 0", addr_pc, err);
    end
    do_instr(mk(3'b101, 8'h50));
    n_vec++;
    if (err !== 1'b1 || halted !== 1'b1) begin
      n_err++; $display("FAIL overflow: err=%b halted=%b want 1 1", err, halted);
    end
    uir = mk(3'b000, 8'h00);
    repeat (6) begin
      @(negedge clk);
      n_vec++;
      if (uir_ld !== 1'b0 || addr_pc !== 8'h40) begin
        n_err++; $display("FAIL halt_absorb: uir_ld=%b addr=%h want 0 40", uir_ld, addr_pc);
      end
    end
    do_reset();
    do_instr(mk(3'b110, 8'h00));
    n_vec++;
    if (err !== 1'b1 || halted !== 1'b1 || addr_pc !== 8'h00) begin
      n_err++; $display("FAIL underflow: err=%b halted=%b addr=%h want 1 1 00", err, halted, addr_pc);
    end
    do_reset();
    do_instr(mk(3'b001, 8'h33));
    do_instr(mk(3'b111, 8'h00));
    n_vec++;
    if (halted !== 1'b1 || err !== 1'b0 || addr_pc !== 8'h33) begin
      n_err++; $display("FAIL halt_seq: halted=%b err=%b addr=%h want 1 0 33", halted, err, addr_pc);
    end
  endtask

  task automatic test_rst_mid_call();
    bit seen;
    do_reset();
    do_instr(mk(3'b001, 8'h10));
    uir = mk(3'b101, 8'h80);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (uir_ld === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL rst_mid_strobe: no uir_ld seen"); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_vec++;
    if (addr_pc !== 8'h00 || err !== 1'b0 || uir_ld !== 1'b0) begin
      n_err++; $display("FAIL rst_mid: addr=%h err=%b uir_ld=%b want 00 0 0", addr_pc, err, uir_ld);
    end
    do_instr(mk(3'b110, 8'h00));
    n_vec++;
    if (err !== 1'b1 || addr_pc !== 8'h00) begin
      n_err++; $display("FAIL rst_mid_stack_empty: err=%b addr=%h want 1 00", err, addr_pc);
    end
  endtask

  initial begin
    test_reset();
    test_next();
    test_wrap();
    test_branch();
    test_map_call_ret();
    test_stack_limits();
    test_rst_mid_call();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
